// File: rtl/color_frame_classifier.sv
// Per-frame red/blue majority classifier on an RGB332 frame-buffer read stream.
// Optional horizontal band position detection is enabled by defining COLOR_POSITION_EN.
module color_frame_classifier #(
    parameter int unsigned SCREEN_W     = 176,
    parameter int unsigned SCREEN_H     = 144,
    parameter int unsigned COLOR_THRESH = 2000
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic [7:0] PIXEL_IN,
    input  logic [9:0] VGA_PIXEL_X,
    input  logic [9:0] VGA_PIXEL_Y,
    input  logic       VGA_VSYNC_NEG,
    output logic [8:0] RESULT,
    output logic       RESULT_VALID
);

    localparam int unsigned COORD_W = 10;
    localparam int unsigned CNT_W   = 15;
    localparam int unsigned SEQ_W   = 5;

    localparam logic [COORD_W-1:0] X_LIM    = COORD_W'(SCREEN_W);
    localparam logic [COORD_W-1:0] Y_LIM    = COORD_W'(SCREEN_H);
    localparam logic [CNT_W-1:0]   CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]   THRESH   = CNT_W'(COLOR_THRESH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_DECIDE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [COORD_W-1:0]   r_x_d;
    logic [COORD_W-1:0]   r_y_d;
    logic                 r_vsync_prev;
    logic [CNT_W-1:0]     r_red_cnt;
    logic [CNT_W-1:0]     r_blue_cnt;
    logic [SEQ_W-1:0]     r_seq;

    logic                 w_frame_edge;
    logic                 w_decide;
    logic                 w_in_win;
    logic                 w_count_en;
    logic                 w_is_red;
    logic                 w_is_blue;
    logic [2:0]           w_r;
    logic [2:0]           w_g;
    logic [1:0]           w_b;
    logic                 w_red_wins;
    logic                 w_blue_wins;
    logic [1:0]           w_color;
    logic [1:0]           w_pos;

    // Pixel data trails its address by one clock, so qualify against delayed coordinates.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_x_d        <= '0;
            r_y_d        <= '0;
            r_vsync_prev <= 1'b1;
        end else begin
            r_x_d        <= VGA_PIXEL_X;
            r_y_d        <= VGA_PIXEL_Y;
            r_vsync_prev <= VGA_VSYNC_NEG;
        end
    end

    assign w_frame_edge = r_vsync_prev & ~VGA_VSYNC_NEG;
    assign w_in_win     = (r_x_d < X_LIM) && (r_y_d < Y_LIM);

    assign w_r       = PIXEL_IN[7:5];
    assign w_g       = PIXEL_IN[4:2];
    assign w_b       = PIXEL_IN[1:0];
    assign w_is_red  = (w_r >= 3'd5) && (w_g <= 3'd2) && (w_b <= 2'd1);
    assign w_is_blue = (w_b == 2'd3) && (w_r <= 3'd2) && (w_g <= 3'd2);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // The decision is registered on the ACCUM->DECIDE edge so the strobe is visible during DECIDE.
    always_comb begin
        w_state_next = r_state;
        w_decide     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_frame_edge) begin
                    w_state_next = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (w_frame_edge) begin
                    w_state_next = ST_DECIDE;
                    w_decide     = 1'b1;
                end
            end
            ST_DECIDE: begin
                w_state_next = ST_ACCUM;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign w_count_en = (r_state == ST_ACCUM) && w_in_win;

    // Counters only run in ACCUM; IDLE holds them at zero and DECIDE clears them.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_red_cnt  <= '0;
            r_blue_cnt <= '0;
        end else if (r_state != ST_ACCUM) begin
            r_red_cnt  <= '0;
            r_blue_cnt <= '0;
        end else begin
            if (w_count_en && w_is_red && (r_red_cnt != CNT_MAX)) begin
                r_red_cnt <= r_red_cnt + CNT_W'(1);
            end
            if (w_count_en && w_is_blue && (r_blue_cnt != CNT_MAX)) begin
                r_blue_cnt <= r_blue_cnt + CNT_W'(1);
            end
        end
    end

    assign w_red_wins  = (r_red_cnt >= THRESH) && (r_red_cnt > r_blue_cnt);
    assign w_blue_wins = (r_blue_cnt >= THRESH) && (r_blue_cnt > r_red_cnt);

    always_comb begin
        w_color = 2'b00;
        if (w_red_wins) begin
            w_color = 2'b01;
        end else if (w_blue_wins) begin
            w_color = 2'b10;
        end
    end

`ifdef COLOR_POSITION_EN
    localparam logic [COORD_W-1:0] BAND_L_LIM = COORD_W'(SCREEN_W / 3);
    localparam logic [COORD_W-1:0] BAND_C_LIM = COORD_W'((2 * SCREEN_W) / 3);

    logic [CNT_W-1:0] r_band_l;
    logic [CNT_W-1:0] r_band_c;
    logic [CNT_W-1:0] r_band_r;
    logic             w_band_en;

    assign w_band_en = w_count_en && (w_is_red || w_is_blue);

    // Column band counters share the color counters' clear behaviour.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_band_l <= '0;
            r_band_c <= '0;
            r_band_r <= '0;
        end else if (r_state != ST_ACCUM) begin
            r_band_l <= '0;
            r_band_c <= '0;
            r_band_r <= '0;
        end else if (w_band_en) begin
            if (r_x_d < BAND_L_LIM) begin
                if (r_band_l != CNT_MAX) r_band_l <= r_band_l + CNT_W'(1);
            end else if (r_x_d < BAND_C_LIM) begin
                if (r_band_c != CNT_MAX) r_band_c <= r_band_c + CNT_W'(1);
            end else begin
                if (r_band_r != CNT_MAX) r_band_r <= r_band_r + CNT_W'(1);
            end
        end
    end

    // Largest band wins; ties resolve center, then left, then right.
    always_comb begin
        w_pos = 2'b00;
        if (w_color != 2'b00) begin
            if ((r_band_c >= r_band_l) && (r_band_c >= r_band_r)) begin
                w_pos = 2'b10;
            end else if (r_band_l >= r_band_r) begin
                w_pos = 2'b01;
            end else begin
                w_pos = 2'b11;
            end
        end
    end
`else
    assign w_pos = 2'b00;
`endif

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            RESULT       <= '0;
            RESULT_VALID <= 1'b0;
            r_seq        <= '0;
        end else begin
            RESULT_VALID <= w_decide;
            if (w_decide) begin
                r_seq  <= r_seq + SEQ_W'(1);
                RESULT <= {r_seq + SEQ_W'(1), w_pos, w_color};
            end
        end
    end

endmodule

// File: doc/color_frame_classifier.md
COLOR_FRAME_CLASSIFIER -- requirements
Module: color_frame_classifier

Interface
REQ-001 Parameters SHALL be: SCREEN_W, default 176, active image width in pixels; SCREEN_H, default 144, active image height in lines; COLOR_THRESH, default 2000, minimum qualifying pixel count per frame.
REQ-002 Port CLK  input  1  25 MHz pixel clock, shared with VGA driver and M9K read port.
REQ-003 Port RESET_N  input  1  asynchronous, active-low reset.
REQ-004 Port PIXEL_IN  input  8  RGB332 pixel from frame buffer read port, {R[2:0],G[2:0],B[1:0]}.
REQ-005 Port VGA_PIXEL_X  input  10  current VGA read column.
REQ-006 Port VGA_PIXEL_Y  input  10  current VGA read row.
REQ-007 Port VGA_VSYNC_NEG  input  1  VGA vertical sync, active low.
REQ-008 Port RESULT  output  9  latched frame classification.
REQ-009 Port RESULT_VALID  output  1  single-cycle strobe when RESULT updates.
REQ-010 One clock; reset is asynchronous and active-low.

Function
REQ-011 PIXEL_IN lags its address by one CLK; block SHALL register VGA_PIXEL_X/Y one cycle and qualify PIXEL_IN against the delayed coordinates.
REQ-012 Pixel in-window iff delayed X < SCREEN_W and delayed Y < SCREEN_H; out-of-window pixels SHALL NOT be counted.
REQ-013 Red pixel: R >= 5, G <= 2, B <= 1. Blue pixel: B == 3, R <= 2, G <= 2. Never both.
REQ-014 Two 15-bit counters RED_CNT, BLUE_CNT SHALL increment by one per qualifying in-window red/blue pixel, saturating at 32767.
REQ-015 Frame boundary = falling edge of VGA_VSYNC_NEG, detected with a registered previous value.
REQ-016 FSM states: IDLE, ACCUM, DECIDE.
REQ-017 IDLE: counters held at 0; on frame boundary -> ACCUM (first partial frame discarded, no RESULT update).
REQ-018 ACCUM: counters run per REQ-014; on frame boundary -> DECIDE.
REQ-019 DECIDE (exactly one cycle): compute color, update RESULT, pulse RESULT_VALID, clear counters, -> ACCUM.
REQ-020 Pixels presented during the DECIDE cycle SHALL be ignored.
REQ-021 RESULT[1:0]: 01 red if RED_CNT >= COLOR_THRESH and RED_CNT > BLUE_CNT; 10 blue if BLUE_CNT >= COLOR_THRESH and BLUE_CNT > RED_CNT; else 00 (includes ties); 11 never produced.
REQ-022 RESULT[8:4]: 5-bit frame sequence number, incremented at each DECIDE, wrapping 31 -> 0.
REQ-023 RESULT[3:2] per Configuration; RESULT holds between DECIDE cycles.
REQ-024 RESULT_VALID latency: asserted the cycle after the cycle the VSYNC falling edge is sampled; high for exactly one cycle.

Reset
REQ-025 RESET_N low SHALL immediately force: FSM IDLE, counters 0, RESULT 9'd0, RESULT_VALID 0, sequence 0, delayed coordinates 0, previous-VSYNC register 1.
REQ-026 Reset mid-frame SHALL discard the partial frame; no RESULT_VALID until the second frame boundary after release.

Configuration
REQ-027 Macro COLOR_POSITION_EN SHALL enable horizontal position detection.
REQ-028 With COLOR_POSITION_EN: three extra 15-bit saturating counters count pixels of the winning-candidate colors per column band: left X < SCREEN_W/3, center X < 2*SCREEN_W/3, right otherwise (integer division); band counts include red and blue pixels; DECIDE sets RESULT[3:2] = 01 left, 10 center, 11 right for the largest band (tie priority center > left > right), 00 if RESULT[1:0] == 00; band counters clear with color counters.
REQ-029 Without COLOR_POSITION_EN: band counters absent, RESULT[3:2] constant 00.

Verification
REQ-030 Reset, then two frames fully red (8'hE0) over 176x144 -> no strobe after first boundary; after second boundary RESULT = {5'd1,2'b00,2'b01}, RESULT_VALID one cycle.
REQ-031 Frame with 1999 blue (8'h03) pixels, rest black -> RESULT[1:0] = 00; same frame with 2000 blue -> 10.
REQ-032 Frame with 3000 red and 3000 blue -> RESULT[1:0] = 00 (tie).
REQ-033 Red (8'hE0) at X = 176..639 and Y >= 144 only -> counters stay 0, RESULT[1:0] = 00.
REQ-034 RESET_N pulsed low mid-ACCUM after 10000 red pixels -> RESULT = 0 immediately; next boundary produces no strobe.
REQ-035 COLOR_POSITION_EN defined, red confined to X = 130..175 (all rows) -> RESULT[3:2] = 11, RESULT[1:0] = 01; sequence wraps 31 -> 0 after 32 decisions.
